fdiv_iter: RTL

FDIV_ITER -- requirements
Module: fdiv_iter

---
 rtl/fdiv_pkg.sv | 26 ++
 rtl/fdiv_round.sv | 63 ++++++
 rtl/fdiv_iter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the iterative floating-point divider.
package fdiv_pkg;

  // Controller states
  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDiv,
    StRound,
    StDone
  } fdiv_state_e;

  // Bit positions inside the 4-bit flags vector {invalid, div_by_zero, overflow, underflow}
  localparam int unsigned NumFlags      = 4;
  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagDivByZero = 2;
  localparam int unsigned FlagOverflow  = 1;
  localparam int unsigned FlagUnderflow = 0;

  // Field constants for the special encodings; replicated to the field width at use
  localparam logic QnanSign   = 1'b0;  // canonical qNaN is positive
  localparam logic QnanManMsb = 1'b1;  // quiet bit, remaining mantissa bits zero
  localparam logic InfExpBit  = 1'b1;  // inf/NaN exponent is all ones
  localparam logic InfManBit  = 1'b0;  // inf mantissa is all zeros

endpackage

// File: rtl/fdiv_round.sv
// Normalise, round-to-nearest-even and range check of the raw restoring-division quotient.
// quot_i carries one integer bit and MAN_W+2 fraction bits; exp_i is the signed biased exponent.
module fdiv_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic        [MAN_W+2:0] quot_i,
  input  logic                    sticky_i,
  output logic        [EXP_W-1:0] exp_o,
  output logic        [MAN_W-1:0] man_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam logic signed [EXP_W+1:0] ExpOne  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] ExpZero = '0;
  localparam logic signed [EXP_W+1:0] ExpInf  = {2'b00, {EXP_W{1'b1}}};

  logic        [MAN_W:0]   sig;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic        [MAN_W+1:0] sig_rnd;
  logic signed [EXP_W+1:0] exp_norm;
  logic signed [EXP_W+1:0] exp_fin;

  // Quotient of two [1,2) significands lies in (0.5,2): shift left once when below 1
  always_comb begin
    if (quot_i[MAN_W+2]) begin
      sig      = quot_i[MAN_W+2:2];
      guard    = quot_i[1];
      sticky   = quot_i[0] | sticky_i;
      exp_norm = exp_i;
    end else begin
      sig      = quot_i[MAN_W+1:1];
      guard    = quot_i[0];
      sticky   = sticky_i;
      exp_norm = exp_i - ExpOne;
    end
  end

  // RNE increment; a carry out of the hidden bit renormalises to 1.0 with e+1
  always_comb begin
    round_up = guard & (sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
    if (sig_rnd[MAN_W+1]) begin
      exp_fin = exp_norm + ExpOne;
      man_o   = sig_rnd[MAN_W:1];
    end else begin
      exp_fin = exp_norm;
      man_o   = sig_rnd[MAN_W-1:0];
    end
  end

  // Out-of-range exponents saturate to inf or flush to zero in the caller
  always_comb begin
    overflow_o  = exp_fin >= ExpInf;
    underflow_o = exp_fin <= ExpZero;
    exp_o       = exp_fin[EXP_W-1:0];
  end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-style divider, one quotient bit per cycle, RNE, no subnormal support.
// Define FDIV_FLAGS_EN to add the registered flags output {invalid, div_by_zero,
// overflow, underflow}.
module fdiv_iter
  import fdiv_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y
`ifdef FDIV_FLAGS_EN
  ,
  output logic [NumFlags-1:0] flags
`endif
);

  localparam int unsigned        CntW     = $clog2(MAN_W + 3);
  localparam logic [CntW-1:0]    CntLast  = CntW'(MAN_W + 2);
  localparam logic [CntW-1:0]    CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0]   Bias     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]       QnanWord = {QnanSign, {EXP_W{InfExpBit}}, QnanManMsb,
                                             {(MAN_W-1){1'b0}}};

  fdiv_state_e             state_q, state_d;
  logic        [W-1:0]     x1_q, x1_d, x2_q, x2_d;
  logic        [W-1:0]     y_q, y_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic        [MAN_W:0]   div_q, div_d;
  logic        [MAN_W+1:0] rem_q, rem_d;
  logic        [MAN_W+2:0] quot_q, quot_d;
  logic        [CntW-1:0]  cnt_q, cnt_d;
`ifdef FDIV_FLAGS_EN
  logic [NumFlags-1:0]     flags_q, flags_d;
  logic                    spec_inv, spec_dbz;
`endif

  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] m1, m2;
  logic             sign_res;
  logic             zero1, zero2, inf1, inf2, nan1, nan2;
  logic             special;
  logic [W-1:0]     spec_y;
  logic             rem_ge;
  logic [MAN_W+1:0] rem_keep;
  logic [EXP_W-1:0] rnd_exp;
  logic [MAN_W-1:0] rnd_man;
  logic             rnd_ovf, rnd_unf;
  logic [W-1:0]     norm_y;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
`ifdef FDIV_FLAGS_EN
  assign flags     = flags_q;
`endif

  // Unpack captured operands; a zero exponent field (zero or subnormal) counts as zero
  always_comb begin
    e1       = x1_q[W-2:MAN_W];
    e2       = x2_q[W-2:MAN_W];
    m1       = x1_q[MAN_W-1:0];
    m2       = x2_q[MAN_W-1:0];
    sign_res = x1_q[W-1] ^ x2_q[W-1];
    zero1    = (e1 == '0);
    zero2    = (e2 == '0);
    inf1     = (&e1) && (m1 == '0);
    inf2     = (&e2) && (m2 == '0);
    nan1     = (&e1) && (m1 != '0);
    nan2     = (&e2) && (m2 != '0);
  end

  // Special-operand result, priority: NaN/invalid, inf dividend, zero divisor, zero result
  always_comb begin
    special = 1'b1;
    spec_y  = '0;
`ifdef FDIV_FLAGS_EN
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
`endif
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      spec_y = QnanWord;
`ifdef FDIV_FLAGS_EN
      spec_inv = 1'b1;
`endif
    end else if (inf1) begin
      spec_y = {sign_res, {EXP_W{InfExpBit}}, {MAN_W{InfManBit}}};
    end else if (zero2) begin
      spec_y = {sign_res, {EXP_W{InfExpBit}}, {MAN_W{InfManBit}}};
`ifdef FDIV_FLAGS_EN
      spec_dbz = 1'b1;
`endif
    end else if (inf2 || zero1) begin
      spec_y = {sign_res, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring-division step: subtract the divisor when it fits, then shift
  always_comb begin
    rem_ge   = rem_q >= {1'b0, div_q};
    rem_keep = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
  end

  fdiv_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .exp_i       (exp_q),
    .quot_i      (quot_q),
    .sticky_i    (|rem_q),
    .exp_o       (rnd_exp),
    .man_o       (rnd_man),
    .overflow_o  (rnd_ovf),
    .underflow_o (rnd_unf)
  );

  // Pack the rounded result, saturating to signed inf or flushing to signed zero
  always_comb begin
    if (rnd_ovf) begin
      norm_y = {sign_q, {EXP_W{InfExpBit}}, {MAN_W{InfManBit}}};
    end else if (rnd_unf) begin
      norm_y = {sign_q, {(W-1){1'b0}}};
    end else begin
      norm_y = {sign_q, rnd_exp, rnd_man};
    end
  end

  // Controller next state and datapath updates
  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y_d     = y_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
`ifdef FDIV_FLAGS_EN
    flags_d = flags_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x1_d    = x1;
          x2_d    = x2;
          state_d = StPrep;
        end
      end
      StPrep: begin
        sign_d = sign_res;
        if (special) begin
          y_d     = spec_y;
          state_d = StDone;
`ifdef FDIV_FLAGS_EN
          flags_d                = '0;
          flags_d[FlagInvalid]   = spec_inv;
          flags_d[FlagDivByZero] = spec_dbz;
`endif
        end else begin
          exp_d   = {2'b00, e1} - {2'b00, e2} + Bias;
          div_d   = {1'b1, m2};
          rem_d   = {2'b01, m1};
          quot_d  = '0;
          cnt_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d  = {rem_keep[MAN_W:0], 1'b0};
        quot_d = {quot_q[MAN_W+1:0], rem_ge};
        cnt_d  = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          state_d = StRound;
        end
      end
      StRound: begin
        y_d     = norm_y;
        state_d = StDone;
`ifdef FDIV_FLAGS_EN
        flags_d                = '0;
        flags_d[FlagOverflow]  = rnd_ovf;
        flags_d[FlagUnderflow] = rnd_unf;
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset aborts any division in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x1_q    <= '0;
      x2_q    <= '0;
      y_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
`ifdef FDIV_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
`ifdef FDIV_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

endmodule
